branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor to the single-issue branch/jump resolution block. It computes jump targets at issue and carries them through a configurable-depth resolve pipeline. At the final stage it evaluates the condition from the ALU flags and drives the fetch redirect and a multi-cycle pipeline flush. Unlike its predecessor, it also redirects on JAL/JALR, squashes wrong-path branches, and keeps resolution statistics. It sits between decode/issue and fetch, beside the ALU.

Parameters:
XLEN, 32, datapath/PC width
RESOLVE_DEPTH, 2, cycles from issue to resolution (>=1)
PC_BIAS, 8, constant subtracted from pc for PC-relative targets
FLUSH_CYCLES, 1, cycles global_reset is held per redirect (>=1)
CNT_W, 16, statistics counter width

Ports:
clock  in  1  sole clock, all state on posedge
reset  in  1  synchronous, active-high
new_jmp  in  1  issue strobe for a branch/jump this cycle
jmp_type  in  3  funct3-style type: 000 BEQ, 001 BNE, 010 JAL, 011 JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
imm  in  XLEN  sign-extended immediate
pc  in  XLEN  PC of the issuing instruction
rs1_val  in  XLEN  base register value (JALR only)
zero  in  1  ALU zero flag, valid for the resolving entry
bit_bus_C  in  1  ALU compare/less-than bit, valid for the resolving entry
new_pc  out  XLEN  redirect target
ctrl_fetch  out  1  fetch takes new_pc this cycle
global_reset  out  1  pipeline flush
busy  out  1  any resolve stage valid, or flush active
branch_count  out  CNT_W  resolved entries
taken_count  out  CNT_W  redirects issued

Behaviour:
- Reset: all stage valids=0, flush counter=0, counters=0. Outputs: new_pc=0, ctrl_fetch=0, global_reset=0, busy=0. Reset mid-flush or mid-pipeline discards everything.
- Issue target computation (combinational, registered into stage 1):
  - Branches and JAL: pc + $signed(imm) - PC_BIAS, modulo 2^XLEN.
  - JALR: (rs1_val + imm) with bit0 cleared.
- Pipeline: RESOLVE_DEPTH stages, each holding {valid, type, target}; entries advance one stage per clock.
  - An entry issued in the cycle sampled by edge E is in the final stage during the cycle after edge E+RESOLVE_DEPTH-1.
  - The entry therefore resolves RESOLVE_DEPTH cycles after the issue cycle.
- Final-stage evaluation (combinational, same cycle). taken =
  - BEQ: zero; BNE: !zero
  - BLT/BLTU: bit_bus_C; BGE/BGEU: !bit_bus_C
  - JAL/JALR: 1
- ctrl_fetch = final_valid & taken & !flush_active.
- new_pc = final-stage target when final_valid, else 0.
- Redirect, on the same posedge as ctrl_fetch=1:
  - Clear valid in all younger stages (wrong path).
  - Load the flush counter with FLUSH_CYCLES.
- global_reset = (flush counter != 0), registered. It goes high the cycle after ctrl_fetch and stays high exactly FLUSH_CYCLES cycles.
- While the flush counter is nonzero:
  - new_jmp is ignored (no entry enters stage 1).
  - Any final-stage entry is discarded without counting.
- Simultaneous issue and redirect in the same cycle: the issuing entry is squashed and not captured.
- Back-to-back branches with no redirect proceed one per cycle, each resolving independently.
- Counters:
  - branch_count increments on every counted final-stage valid.
  - taken_count increments on every redirect.
  - Both saturate at 2^CNT_W-1, with no wrap.
- busy = OR of stage valids OR flush_active.

Test Plan:
- Taken BEQ: defaults; pc=0x100, imm=0x20, type=000, new_jmp for 1 cycle; zero=1 two cycles later -> ctrl_fetch=1, new_pc=0x118 that cycle; global_reset=1 next cycle only; taken_count=1, branch_count=1.
- Not-taken BNE: pc=0x40, imm=-4, zero=1 at resolve -> ctrl_fetch stays 0, global_reset stays 0, new_pc=0x34 shown; branch_count=1, taken_count=0.
- JALR alignment: rs1_val=0x1003, imm=0x10, type=011 -> redirect with new_pc=0x1012 regardless of flags.
- Squash: BGE (bit_bus_C=0, taken) issued, then BLT issued next cycle; FLUSH_CYCLES=3 -> one redirect only; BLT never resolves; global_reset high 3 cycles; new_jmp during those cycles is ignored; branch_count=1.
- Reset mid-flight: issue JAL, assert reset the next cycle -> no ctrl_fetch, all outputs 0, busy=0.
- Saturation: CNT_W=2, 5 taken JALs spaced 3 cycles apart -> taken_count holds at 3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves branches and jumps for a single-issue pipeline. The jump target is
// computed when the instruction issues, then carried through a resolve
// pipeline RESOLVE_DEPTH stages deep. In the final stage the branch condition
// is evaluated from the ALU flags. A taken branch, JAL or JALR redirects
// fetch, squashes the younger wrong-path entries and holds a pipeline flush
// for FLUSH_CYCLES cycles. Saturating counters record how many entries
// resolved and how many redirects were issued.
//
// Ports
//   clock         sole clock; all state updates on posedge
//   reset         synchronous, active-high; discards all in-flight state
//   new_jmp       issue strobe for a branch/jump this cycle
//   jmp_type      000 BEQ, 001 BNE, 010 JAL, 011 JALR,
//                 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
//   imm           sign-extended immediate
//   pc            PC of the issuing instruction
//   rs1_val       base register value, used by JALR only
//   zero          ALU zero flag for the resolving entry
//   bit_bus_C     ALU less-than bit for the resolving entry
//   new_pc        redirect target (final-stage target, or 0 if that stage is empty)
//   ctrl_fetch    fetch takes new_pc this cycle
//   global_reset  pipeline flush, held FLUSH_CYCLES cycles after a redirect
//   busy          some resolve stage is occupied, or a flush is in progress
//   branch_count  resolved entries (saturating)
//   taken_count   redirects issued (saturating)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned RESOLVE_DEPTH = 2,
  parameter int unsigned PC_BIAS       = 8,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             new_jmp,
  input  logic [2:0]       jmp_type,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic             zero,
  input  logic             bit_bus_C,
  output logic [XLEN-1:0]  new_pc,
  output logic             ctrl_fetch,
  output logic             global_reset,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  // Jump type encodings (funct3 style).
  localparam logic [2:0] JT_BEQ  = 3'b000;
  localparam logic [2:0] JT_BNE  = 3'b001;
  localparam logic [2:0] JT_JAL  = 3'b010;
  localparam logic [2:0] JT_JALR = 3'b011;
  localparam logic [2:0] JT_BLT  = 3'b100;
  localparam logic [2:0] JT_BGE  = 3'b101;
  localparam logic [2:0] JT_BLTU = 3'b110;
  localparam logic [2:0] JT_BGEU = 3'b111;

  localparam int unsigned   LAST       = RESOLVE_DEPTH - 1;
  localparam int unsigned   FLUSH_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES);
  localparam logic [XLEN-1:0]    BIAS       = XLEN'(PC_BIAS);
  // JALR targets are halfword aligned: bit 0 is always cleared.
  localparam logic [XLEN-1:0]    ALIGN_MASK = ~XLEN'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [RESOLVE_DEPTH-1:0] valid_q, valid_d;
  logic [2:0]               type_q   [RESOLVE_DEPTH];
  logic [2:0]               type_d   [RESOLVE_DEPTH];
  logic [XLEN-1:0]          target_q [RESOLVE_DEPTH];
  logic [XLEN-1:0]          target_d [RESOLVE_DEPTH];
  logic [FLUSH_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]         branch_count_q, branch_count_d;
  logic [CNT_W-1:0]         taken_count_q, taken_count_d;

  // -------------------------------------------------------------------------
  // Issue-side target computation
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] issue_target;

  assign jalr_sum = rs1_val + imm;

  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    issue_target = '0;
    if (jmp_type == JT_JALR) begin
      issue_target = jalr_sum & ALIGN_MASK;
    end else begin
      // Adding the two's-complement immediate is the signed add modulo 2^XLEN.
      issue_target = pc + imm - BIAS;
    end
  end

  // -------------------------------------------------------------------------
  // Final-stage evaluation
  // -------------------------------------------------------------------------
  logic            final_valid;
  logic [2:0]      final_type;
  logic [XLEN-1:0] final_target;
  logic            taken;
  logic            flush_active;
  logic            redirect;
  logic            issue_accept;
  logic            count_branch;

  assign final_valid  = valid_q[LAST];
  assign final_type   = type_q[LAST];
  assign final_target = target_q[LAST];

  always_comb begin
    taken = 1'b0;
    case (final_type)
      JT_BEQ:          taken = zero;
      JT_BNE:          taken = ~zero;
      JT_JAL, JT_JALR: taken = 1'b1;
      JT_BLT, JT_BLTU: taken = bit_bus_C;
      JT_BGE, JT_BGEU: taken = ~bit_bus_C;
      default:         taken = 1'b0;
    endcase
  end

  assign flush_active = (flush_cnt_q != '0);

  // While a flush is running the final stage is neither acted on nor counted.
  assign redirect     = final_valid & taken & ~flush_active;
  assign count_branch = final_valid & ~flush_active;

  // A new issue is dropped during a flush, and also in the redirect cycle
  // itself because it lies on the wrong path of the redirecting branch.
  assign issue_accept = new_jmp & ~flush_active & ~redirect;

  // -------------------------------------------------------------------------
  // Pipeline advance
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d     = '0;
    valid_d[0]  = issue_accept;
    type_d[0]   = jmp_type;
    target_d[0] = issue_target;
    for (int i = 1; i < int'(RESOLVE_DEPTH); i++) begin
      // A redirect kills every younger entry; the final entry retires anyway.
      valid_d[i]  = valid_q[i-1] & ~redirect;
      type_d[i]   = type_q[i-1];
      target_d[i] = target_q[i-1];
    end
  end

  // -------------------------------------------------------------------------
  // Flush counter and statistics
  // -------------------------------------------------------------------------
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (redirect) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_active) begin
      flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
    end
  end

  always_comb begin
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    // Both counters stick at all-ones rather than wrapping.
    if (count_branch && (branch_count_q != '1)) begin
      branch_count_d = branch_count_q + CNT_W'(1);
    end
    if (redirect && (taken_count_q != '1)) begin
      taken_count_d = taken_count_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      valid_q        <= '0;
      flush_cnt_q    <= '0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      valid_q        <= valid_d;
      flush_cnt_q    <= flush_cnt_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  // NOTE: the stage payload is deliberately not reset; it is only ever looked
  // at under its valid bit, so resetting it would add reset fan-out for nothing.
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(RESOLVE_DEPTH); i++) begin
      type_q[i]   <= type_d[i];
      target_q[i] <= target_d[i];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ctrl_fetch   = redirect;
  assign new_pc       = final_valid ? final_target : '0;
  assign global_reset = flush_active;
  assign busy         = (|valid_q) | flush_active;
  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// Directed testbench for branch_resolve_unit. Three instances share one
// stimulus stream: u_def (default parameters), u_f3 (FLUSH_CYCLES=3) and
// u_c2 (CNT_W=2). Inputs change on the falling edge; outputs are checked
// 1 time unit later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        new_jmp;
  logic [2:0]  jmp_type;
  logic [31:0] imm, pc, rs1_val;
  logic        zero, bit_bus_C;

  logic [31:0] new_pc_a, new_pc_f, new_pc_c;
  logic        fetch_a, fetch_f, fetch_c;
  logic        grst_a, grst_f, grst_c;
  logic        busy_a, busy_f, busy_c;
  logic [15:0] bcnt_a, tcnt_a, bcnt_f, tcnt_f;
  logic [1:0]  bcnt_c, tcnt_c;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  branch_resolve_unit u_def (
    .clock(clock), .reset(reset), .new_jmp(new_jmp), .jmp_type(jmp_type),
    .imm(imm), .pc(pc), .rs1_val(rs1_val), .zero(zero), .bit_bus_C(bit_bus_C),
    .new_pc(new_pc_a), .ctrl_fetch(fetch_a), .global_reset(grst_a), .busy(busy_a),
    .branch_count(bcnt_a), .taken_count(tcnt_a)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(3)) u_f3 (
    .clock(clock), .reset(reset), .new_jmp(new_jmp), .jmp_type(jmp_type),
    .imm(imm), .pc(pc), .rs1_val(rs1_val), .zero(zero), .bit_bus_C(bit_bus_C),
    .new_pc(new_pc_f), .ctrl_fetch(fetch_f), .global_reset(grst_f), .busy(busy_f),
    .branch_count(bcnt_f), .taken_count(tcnt_f)
  );

  branch_resolve_unit #(.CNT_W(2)) u_c2 (
    .clock(clock), .reset(reset), .new_jmp(new_jmp), .jmp_type(jmp_type),
    .imm(imm), .pc(pc), .rs1_val(rs1_val), .zero(zero), .bit_bus_C(bit_bus_C),
    .new_pc(new_pc_c), .ctrl_fetch(fetch_c), .global_reset(grst_c), .busy(busy_c),
    .branch_count(bcnt_c), .taken_count(tcnt_c)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    new_jmp = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] p,
                       input logic [31:0] i, input logic [31:0] r);
    new_jmp  = 1'b1;
    jmp_type = t;
    pc       = p;
    imm      = i;
    rs1_val  = r;
  endtask

  initial begin
    reset = 1'b1; new_jmp = 1'b0; jmp_type = 3'b000;
    imm = '0; pc = '0; rs1_val = '0; zero = 1'b0; bit_bus_C = 1'b0;

    // ---------------- reset state ----------------
    apply_reset();
    settle();
    check("rst_new_pc",  new_pc_a, 32'h0);
    check("rst_fetch",   32'(fetch_a), 32'h0);
    check("rst_grst",    32'(grst_a), 32'h0);
    check("rst_busy",    32'(busy_a), 32'h0);
    check("rst_bcnt",    32'(bcnt_a), 32'h0);
    check("rst_tcnt",    32'(tcnt_a), 32'h0);

    // ---------------- taken BEQ ----------------
    step(); issue(3'b000, 32'h100, 32'h20, 32'h0); zero = 1'b0; settle();
    check("beq_issue_fetch", 32'(fetch_a), 32'h0);
    step(); new_jmp = 1'b0; settle();
    check("beq_s1_busy",  32'(busy_a), 32'h1);
    check("beq_s1_fetch", 32'(fetch_a), 32'h0);
    step(); zero = 1'b1; settle();
    check("beq_fetch",  32'(fetch_a), 32'h1);
    check("beq_new_pc", new_pc_a, 32'h118);
    check("beq_grst0",  32'(grst_a), 32'h0);
    step(); zero = 1'b0; settle();
    check("beq_grst1",  32'(grst_a), 32'h1);
    check("beq_fetch_after", 32'(fetch_a), 32'h0);
    check("beq_tcnt",   32'(tcnt_a), 32'h1);
    check("beq_bcnt",   32'(bcnt_a), 32'h1);
    step(); settle();
    check("beq_grst_end", 32'(grst_a), 32'h0);
    check("beq_busy_end", 32'(busy_a), 32'h0);

    // ---------------- not-taken BNE, then back-to-back BEQs ----------------
    apply_reset();
    step(); issue(3'b001, 32'h40, 32'hFFFF_FFFC, 32'h0);
    step(); issue(3'b000, 32'h80, 32'h8, 32'h0);
    step(); issue(3'b000, 32'h90, 32'h10, 32'h0); zero = 1'b1; settle();
    check("bne_fetch",  32'(fetch_a), 32'h0);
    check("bne_new_pc", new_pc_a, 32'h34);
    step(); new_jmp = 1'b0; zero = 1'b0; settle();
    check("b2b1_fetch",  32'(fetch_a), 32'h0);
    check("b2b1_new_pc", new_pc_a, 32'h80);
    check("bne_grst",    32'(grst_a), 32'h0);
    step(); settle();
    check("b2b2_fetch",  32'(fetch_a), 32'h0);
    check("b2b2_new_pc", new_pc_a, 32'h98);
    step(); settle();
    check("b2b_bcnt",   32'(bcnt_a), 32'h3);
    check("b2b_tcnt",   32'(tcnt_a), 32'h0);
    check("b2b_busy",   32'(busy_a), 32'h0);
    check("idle_new_pc", new_pc_a, 32'h0);

    // ---------------- JALR alignment ----------------
    step(); issue(3'b011, 32'h500, 32'h10, 32'h1003); zero = 1'b1; bit_bus_C = 1'b1;
    step(); new_jmp = 1'b0;
    step(); zero = 1'b0; bit_bus_C = 1'b0; settle();
    check("jalr_fetch",  32'(fetch_a), 32'h1);
    check("jalr_new_pc", new_pc_a, 32'h1012);
    step(); settle();
    check("jalr_grst", 32'(grst_a), 32'h1);
    check("jalr_tcnt", 32'(tcnt_a), 32'h1);
    check("jalr_bcnt", 32'(bcnt_a), 32'h4);

    // ---------------- squash with FLUSH_CYCLES=3 ----------------
    apply_reset();
    step(); issue(3'b101, 32'h200, 32'h40, 32'h0); bit_bus_C = 1'b0;
    step(); issue(3'b100, 32'h204, 32'h80, 32'h0);
    // The JAL issued in the redirect cycle must be squashed.
    step(); issue(3'b010, 32'h300, 32'h0, 32'h0); settle();
    check("sq_fetch",  32'(fetch_f), 32'h1);
    check("sq_new_pc", new_pc_f, 32'h238);
    // BLT would be taken here if it had survived.
    step(); bit_bus_C = 1'b1; settle();
    check("sq_grst_c1",  32'(grst_f), 32'h1);
    check("sq_fetch_c1", 32'(fetch_f), 32'h0);
    check("sq_busy_c1",  32'(busy_f), 32'h1);
    step(); settle();
    check("sq_grst_c2",  32'(grst_f), 32'h1);
    check("sq_fetch_c2", 32'(fetch_f), 32'h0);
    step(); new_jmp = 1'b0; settle();
    check("sq_grst_c3",  32'(grst_f), 32'h1);
    check("sq_fetch_c3", 32'(fetch_f), 32'h0);
    step(); settle();
    check("sq_grst_end", 32'(grst_f), 32'h0);
    check("sq_fetch_end", 32'(fetch_f), 32'h0);
    check("sq_busy_end", 32'(busy_f), 32'h0);
    step(); settle();
    check("sq_fetch_late", 32'(fetch_f), 32'h0);
    check("sq_bcnt", 32'(bcnt_f), 32'h1);
    check("sq_tcnt", 32'(tcnt_f), 32'h1);
    bit_bus_C = 1'b0;

    // ---------------- reset mid-flight ----------------
    apply_reset();
    step(); issue(3'b010, 32'h100, 32'h0, 32'h0);
    step(); new_jmp = 1'b0; reset = 1'b1;
    step(); reset = 1'b0; settle();
    check("rmf_fetch",  32'(fetch_a), 32'h0);
    check("rmf_new_pc", new_pc_a, 32'h0);
    check("rmf_grst",   32'(grst_a), 32'h0);
    check("rmf_busy",   32'(busy_a), 32'h0);
    check("rmf_bcnt",   32'(bcnt_a), 32'h0);
    step(); settle();
    check("rmf_fetch2", 32'(fetch_a), 32'h0);
    check("rmf_tcnt",   32'(tcnt_a), 32'h0);

    // ---------------- counter saturation with CNT_W=2 ----------------
    apply_reset();
    for (int n = 0; n < 5; n++) begin
      step(); issue(3'b010, 32'h1000, 32'h40, 32'h0);
      step(); new_jmp = 1'b0;
      step(); settle();
      check("sat_fetch", 32'(fetch_c), 32'h1);
      step();
      if (n == 3) begin
        settle();
        check("sat_tcnt_4th", 32'(tcnt_c), 32'h3);
      end
    end
    step(); settle();
    check("sat_tcnt_c2", 32'(tcnt_c), 32'h3);
    check("sat_bcnt_c2", 32'(bcnt_c), 32'h3);
    check("sat_tcnt_def", 32'(tcnt_a), 32'h5);
    check("sat_bcnt_def", 32'(bcnt_a), 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
